spy_chain_probe_ctrl: RTL and testbench
=======================================

Name: spy_chain_probe_ctrl

Overview:
- Sequencer for one spy delay chain, e.g. a 100-stage NOT-element chain instance.
- Per trial it:
  - drives a clean edge into the chain's pathInput;
  - waits a programmable number of clocks;
  - captures pathResult and compares it with the value the settled chain must produce.
- Runs a requested number of trials with alternating rising/falling launches and counts late (mismatching) captures.
- Sits between the software-visible measurement registers and the chain instance.

Parameters:
- TRIAL_W, 16, width of numTrials / trialCount / errCount.
- WAIT_W, 8, width of waitCycles.
- SETTLE_CYCLES, 16, quiet cycles before every launch so the chain is fully settled (must be >= 1).
- INVERTING, 0, chain polarity: 1 = odd number of NOT stages (pathResult settles to ~pathInput); 0 = even, e.g. 100-stage (settles to pathInput).

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request to begin a run; sampled only in IDLE.
- abort, input, 1, stop the run at the next clock edge.
- numTrials, input, TRIAL_W, trials per run; latched on accepted start.
- waitCycles, input, WAIT_W, launch-to-capture distance; latched on accepted start.
- pathInput, output, 1, registered drive into the chain.
- pathResult, input, 1, chain output.
- busy, output, 1, high from accepted start until DONE/IDLE.
- done, output, 1, one-cycle pulse at run completion; never pulses on abort.
- trialCount, output, TRIAL_W, trials completed in the current/last run.
- errCount, output, TRIAL_W, mismatching captures; saturates at all-ones.

Behaviour:
- Reset: FSM=IDLE; pathInput=0, busy=0, done=0, trialCount=0, errCount=0; all internal counters=0. Reset mid-run behaves identically; no done.
- FSM states: IDLE, SETTLE, LAUNCH, WAIT, CAPTURE, CHECK, DONE.
- IDLE:
  - start=1 latches numTrials/waitCycles, clears trialCount/errCount, sets busy.
  - If latched numTrials==0, go to DONE; else go to SETTLE.
- SETTLE: pathInput held; count SETTLE_CYCLES clocks, then LAUNCH.
- LAUNCH (1 cycle): pathInput <= ~pathInput, registered. Expected value exp = ~old pathInput ^ INVERTING. Wait counter loads waitCycles.
  - waitCycles==0: go to CAPTURE.
  - else: go to WAIT.
- WAIT: decrement each clock; at 1, go to CAPTURE.
- Timing: the capture flop samples pathResult at edge L+1+waitCycles, where L is the edge at which pathInput toggled. Minimum distance is one clock.
- CAPTURE (1 cycle): cap <= pathResult. Then CHECK.
- CHECK (1 cycle):
  - If cap != exp, errCount++ (hold at all-ones if saturated).
  - trialCount++.
  - If trialCount+1 == latched numTrials, go to DONE; else go to SETTLE.
- DONE (1 cycle): done=1, busy=0; then IDLE. trialCount/errCount hold until the next accepted start.
- Trial polarity: first trial after reset is rising (pathInput 0->1); trials then alternate. pathInput is not forced back to 0 between runs, so a run's first edge polarity equals the inverse of its current level.
- start while busy: ignored.
- abort: takes priority over every state transition except rst. Next state is IDLE, busy=0, no done. pathInput, trialCount and errCount hold their values.
- abort and start in the same IDLE cycle: abort wins; start is dropped.
- Wrap-around: numTrials = all-ones runs 2^TRIAL_W-1 trials; trialCount never wraps.
- waitCycles latched value is immune to input changes mid-run.

Optional Feature:
- Macro: SPY_EDGE_SPLIT_EN.
- Defined:
  - Adds outputs errRise and errFall (TRIAL_W each, saturating), counting mismatches of rising- and falling-launch trials separately.
  - Both clear on accepted start and reset.
  - errCount still equals the saturated total.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Ideal chain model (pathResult = pathInput after 3 clocks), INVERTING=0, numTrials=10, waitCycles=5 -> done after 10 trials; trialCount=10, errCount=0; pathInput toggles 10 times, ending at 0.
- Same model, waitCycles=1 -> every capture is late; errCount=10. With SPY_EDGE_SPLIT_EN: errRise=5, errFall=5.
- numTrials=0 -> done pulses 2 cycles after start; trialCount=0, errCount=0; pathInput unchanged.
- Model delay 3 clocks, waitCycles=2 vs waitCycles=3 -> errCount=numTrials (4) vs 0. Confirms the L+1+waitCycles capture edge exactly.
- abort asserted in WAIT of trial 3 of 8 -> IDLE next cycle, busy=0, no done, trialCount=2; a new start with numTrials=2 completes normally. rst asserted mid-run -> all outputs 0 next cycle.
- start pulsed while busy, and TRIAL_W=4 with numTrials=15 and all captures failing -> start ignored; errCount=15 with no wrap; done exactly once.

Source files
------------

// File: rtl/spy_chain_probe_ctrl_if.sv
// Bundle for spy_chain_probe_ctrl: the measurement-register handshake, the
// run results and the two chain taps (pathInput drive, pathResult return).
// When SPY_EDGE_SPLIT_EN is defined, the split per-edge error counters are added.
interface spy_chain_probe_ctrl_if #(
  parameter int TRIAL_W = 16,
  parameter int WAIT_W  = 8
);
  logic               start;
  logic               abort;
  logic [TRIAL_W-1:0] numTrials;
  logic [WAIT_W-1:0]  waitCycles;
  logic               pathInput;
  logic               pathResult;
  logic               busy;
  logic               done;
  logic [TRIAL_W-1:0] trialCount;
  logic [TRIAL_W-1:0] errCount;
`ifdef SPY_EDGE_SPLIT_EN
  logic [TRIAL_W-1:0] errRise;
  logic [TRIAL_W-1:0] errFall;

  modport master (
    output start, abort, numTrials, waitCycles, pathResult,
    input  pathInput, busy, done, trialCount, errCount, errRise, errFall
  );

  modport slave (
    input  start, abort, numTrials, waitCycles, pathResult,
    output pathInput, busy, done, trialCount, errCount, errRise, errFall
  );
`else
  modport master (
    output start, abort, numTrials, waitCycles, pathResult,
    input  pathInput, busy, done, trialCount, errCount
  );

  modport slave (
    input  start, abort, numTrials, waitCycles, pathResult,
    output pathInput, busy, done, trialCount, errCount
  );
`endif
endinterface

// File: rtl/spy_chain_probe_ctrl.sv
// Trial sequencer for one spy delay chain: settle, launch an edge into the
// chain, wait a programmable number of clocks, capture and compare the chain
// output, and count late captures over a run of alternating-edge trials.
// Optional macro SPY_EDGE_SPLIT_EN adds separate rising/falling error counters.
module spy_chain_probe_ctrl #(
  parameter int TRIAL_W       = 16,
  parameter int WAIT_W        = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter bit INVERTING     = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  spy_chain_probe_ctrl_if.slave bus
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_LAUNCH  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  logic [2:0]         state_q, state_d;
  logic               path_q, path_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TRIAL_W-1:0] trial_q, trial_d;
  logic [TRIAL_W-1:0] err_q, err_d;
  logic [TRIAL_W-1:0] num_q, num_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic [SET_W-1:0]   scnt_q, scnt_d;
  logic               exp_q, exp_d;
  logic               rise_q, rise_d;
  logic               cap_q, cap_d;
  logic [TRIAL_W-1:0] trial_inc;
`ifdef SPY_EDGE_SPLIT_EN
  logic [TRIAL_W-1:0] err_rise_q, err_rise_d;
  logic [TRIAL_W-1:0] err_fall_q, err_fall_d;
`endif

  assign trial_inc = trial_q + 1'b1;

  // Next-state logic; abort overrides every transition and freezes results.
  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    trial_d = trial_q;
    err_d   = err_q;
    num_d   = num_q;
    wait_d  = wait_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    exp_d   = exp_q;
    rise_d  = rise_q;
    cap_d   = cap_q;
`ifdef SPY_EDGE_SPLIT_EN
    err_rise_d = err_rise_q;
    err_fall_d = err_fall_q;
`endif
    if (bus.abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            num_d   = bus.numTrials;
            wait_d  = bus.waitCycles;
            trial_d = '0;
            err_d   = '0;
`ifdef SPY_EDGE_SPLIT_EN
            err_rise_d = '0;
            err_fall_d = '0;
`endif
            busy_d  = 1'b1;
            scnt_d  = '0;
            state_d = (bus.numTrials == '0) ? ST_DONE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (scnt_q == SETTLE_LAST) begin
            scnt_d  = '0;
            state_d = ST_LAUNCH;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        ST_LAUNCH: begin
          // The edge leaves the flop here; the settled chain must show exp.
          path_d  = ~path_q;
          exp_d   = ~path_q ^ INVERTING;
          rise_d  = ~path_q;
          wcnt_d  = wait_q;
          state_d = (wait_q == '0) ? ST_CAPTURE : ST_WAIT;
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == WAIT_W'(1)) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          cap_d   = bus.pathResult;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (cap_q != exp_q) begin
            if (err_q != '1) err_d = err_q + 1'b1;
`ifdef SPY_EDGE_SPLIT_EN
            if (rise_q) begin
              if (err_rise_q != '1) err_rise_d = err_rise_q + 1'b1;
            end else begin
              if (err_fall_q != '1) err_fall_d = err_fall_q + 1'b1;
            end
`endif
          end
          trial_d = trial_inc;
          scnt_d  = '0;
          state_d = (trial_inc == num_q) ? ST_DONE : ST_SETTLE;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      path_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trial_q <= '0;
      err_q   <= '0;
      num_q   <= '0;
      wait_q  <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      exp_q   <= 1'b0;
      rise_q  <= 1'b0;
      cap_q   <= 1'b0;
`ifdef SPY_EDGE_SPLIT_EN
      err_rise_q <= '0;
      err_fall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trial_q <= trial_d;
      err_q   <= err_d;
      num_q   <= num_d;
      wait_q  <= wait_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      exp_q   <= exp_d;
      rise_q  <= rise_d;
      cap_q   <= cap_d;
`ifdef SPY_EDGE_SPLIT_EN
      err_rise_q <= err_rise_d;
      err_fall_q <= err_fall_d;
`endif
    end
  end

  assign bus.pathInput  = path_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.trialCount = trial_q;
  assign bus.errCount   = err_q;
`ifdef SPY_EDGE_SPLIT_EN
  assign bus.errRise    = err_rise_q;
  assign bus.errFall    = err_fall_q;
`endif

endmodule

// File: tb/tb_spy_chain_probe_ctrl.sv
// Directed bench for spy_chain_probe_ctrl: a 3-clock ideal chain model feeds
// each instance; a 16-bit instance covers run timing, capture edge, abort and
// reset, and a 4-bit instance covers start-while-busy and full-count errors.
module tb_spy_chain_probe_ctrl;

  logic clk = 1'b0;
  logic rst;

  int n_assert = 0;
  int n_fail   = 0;

  spy_chain_probe_ctrl_if #(.TRIAL_W(16), .WAIT_W(8)) bus ();
  spy_chain_probe_ctrl_if #(.TRIAL_W(4),  .WAIT_W(8)) bus4 ();

  spy_chain_probe_ctrl #(
    .TRIAL_W(16), .WAIT_W(8), .SETTLE_CYCLES(16), .INVERTING(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spy_chain_probe_ctrl #(
    .TRIAL_W(4), .WAIT_W(8), .SETTLE_CYCLES(4), .INVERTING(1'b0)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  // Ideal chain models: output follows input three clocks later.
  logic [2:0] dly, dly4;
  always @(posedge clk) begin
    if (rst) begin
      dly  <= '0;
      dly4 <= '0;
    end else begin
      dly  <= {dly[1:0], bus.pathInput};
      dly4 <= {dly4[1:0], bus4.pathInput};
    end
  end
  assign bus.pathResult  = dly[2];
  assign bus4.pathResult = dly4[2];

  // Monotonic event counters sampled mid-cycle.
  int toggles = 0, done_cnt = 0, done4_cnt = 0;
  logic prev_pi = 1'b0;
  always @(negedge clk) begin
    if (bus.pathInput !== prev_pi) toggles++;
    prev_pi = bus.pathInput;
    if (bus.done === 1'b1) done_cnt++;
    if (bus4.done === 1'b1) done4_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic do_start(input logic [15:0] n, input logic [7:0] w);
    @(negedge clk);
    bus.numTrials  = n;
    bus.waitCycles = w;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Negedges after do_start until done is seen; 0 means the bound expired.
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc, t0, d0, found;
    logic pi;
    rst = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.numTrials = '0;  bus.waitCycles = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.numTrials = '0; bus4.waitCycles = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy",   bus.busy, 0);
    check("reset_done",   bus.done, 0);
    check("reset_path",   bus.pathInput, 0);
    check("reset_trials", bus.trialCount, 0);
    check("reset_errs",   bus.errCount, 0);
    check("reset4_trials", bus4.trialCount, 0);

    // 10 trials, wait 5: all captures settled. Inputs changed mid-run are ignored.
    t0 = toggles;
    do_start(16'd10, 8'd5);
    check("run1_busy", bus.busy, 1);
    bus.waitCycles = 8'd0;
    bus.numTrials  = 16'd1;
    wait_done(400, cyc);
    check("run1_cycles", cyc, 241);
    check("run1_trials", bus.trialCount, 10);
    check("run1_errs",   bus.errCount, 0);
    check("run1_busy_end", bus.busy, 0);
    check("run1_toggles", toggles - t0, 10);
    check("run1_path",   bus.pathInput, 0);
    @(negedge clk);
    check("run1_done_pulse", bus.done, 0);

    // wait 1: every capture precedes the chain output.
    do_start(16'd10, 8'd1);
    wait_done(400, cyc);
    check("late_cycles", cyc, 201);
    check("late_trials", bus.trialCount, 10);
    check("late_errs",   bus.errCount, 10);
`ifdef SPY_EDGE_SPLIT_EN
    check("late_rise", bus.errRise, 5);
    check("late_fall", bus.errFall, 5);
`endif

    // Zero trials: done two cycles after start, nothing launched.
    t0 = toggles;
    do_start(16'd0, 8'd5);
    wait_done(10, cyc);
    check("zero_cycles",  cyc, 1);
    check("zero_trials",  bus.trialCount, 0);
    check("zero_errs",    bus.errCount, 0);
    check("zero_toggles", toggles - t0, 0);

    // Capture edge L+1+waitCycles against a 3-clock chain.
    do_start(16'd4, 8'd2);
    wait_done(200, cyc);
    check("w2_cycles", cyc, 85);
    check("w2_errs",   bus.errCount, 4);
    do_start(16'd4, 8'd3);
    wait_done(200, cyc);
    check("w3_cycles", cyc, 89);
    check("w3_errs",   bus.errCount, 0);

    // Abort in WAIT of trial 3 of 8.
    do_start(16'd8, 8'd5);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.trialCount == 16'd2) begin found = 1; break; end
    end
    check("abort_reach_t2", found, 1);
    pi = bus.pathInput;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pathInput !== pi) begin found = 1; break; end
    end
    check("abort_reach_launch", found, 1);
    d0 = done_cnt;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy",   bus.busy, 0);
    check("abort_done",   bus.done, 0);
    check("abort_trials", bus.trialCount, 2);
    check("abort_path",   bus.pathInput, 1);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle",    bus.busy, 0);

    do_start(16'd2, 8'd5);
    wait_done(100, cyc);
    check("rerun_cycles", cyc, 49);
    check("rerun_trials", bus.trialCount, 2);
    check("rerun_errs",   bus.errCount, 0);
    check("rerun_path",   bus.pathInput, 1);

    // abort and start together in IDLE: start is dropped.
    @(negedge clk);
    bus.numTrials = 16'd5;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    check("abort_start_trials", bus.trialCount, 2);

    // Reset mid-run while pathInput is high.
    do_start(16'd5, 8'd5);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.trialCount == 16'd1) begin found = 1; break; end
    end
    check("rst_reach_t1", found, 1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pathInput === 1'b1) begin found = 1; break; end
    end
    check("rst_reach_high", found, 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_path",   bus.pathInput, 0);
    check("rst_busy",   bus.busy, 0);
    check("rst_done",   bus.done, 0);
    check("rst_trials", bus.trialCount, 0);
    check("rst_errs",   bus.errCount, 0);
    repeat (10) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);

    // 4-bit instance: 15 failing trials, a stray start mid-run.
    d0 = done4_cnt;
    @(negedge clk);
    bus4.numTrials  = 4'd15;
    bus4.waitCycles = 8'd0;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 20) begin bus4.numTrials = 4'd3; bus4.start = 1'b1; end
      if (i == 21) bus4.start = 1'b0;
      if (bus4.done === 1'b1) begin cyc = i; break; end
    end
    check("w4_cycles", cyc, 106);
    check("w4_trials", bus4.trialCount, 15);
    check("w4_errs",   bus4.errCount, 15);
    check("w4_path",   bus4.pathInput, 1);
`ifdef SPY_EDGE_SPLIT_EN
    check("w4_rise", bus4.errRise, 8);
    check("w4_fall", bus4.errFall, 7);
`endif
    repeat (20) @(negedge clk);
    check("w4_done_once", done4_cnt - d0, 1);
    check("w4_errs_hold", bus4.errCount, 15);
    check("w4_busy_end",  bus4.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
